// File: rtl/alu_op_sequencer.sv
// Command sequencer that drives an external 8-bit ALU and runs multi-cycle shifts
// itself, returning each result over a valid/ready response channel.
module alu_op_sequencer (
  input  logic       clock,
  input  logic       clear,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [2:0] alu_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_ovf,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_ovf,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ALU, S_SHIFT, S_RESP} state_t;

  state_t     state_q, state_d;
  logic [2:0] alu_sel_q, alu_sel_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] count_q, count_d;
  logic       sticky_q, sticky_d;
  logic       dir_right_q, dir_right_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_ovf_q, rsp_ovf_d;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= S_IDLE;
      alu_sel_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      shreg_q     <= '0;
      count_q     <= '0;
      sticky_q    <= 1'b0;
      dir_right_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      shreg_q     <= shreg_d;
      count_q     <= count_d;
      sticky_q    <= sticky_d;
      dir_right_q <= dir_right_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    shreg_d     = shreg_q;
    count_d     = count_q;
    sticky_d    = sticky_q;
    dir_right_d = dir_right_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Shifts are handled locally; the ALU operand registers keep their last values.
          if (cmd_op[2:1] == 2'b11) begin
            shreg_d     = cmd_a;
            count_d     = cmd_b[2:0];
            sticky_d    = 1'b0;
            dir_right_d = cmd_op[0];
            state_d     = S_SHIFT;
          end else begin
            alu_sel_d = cmd_op;
            alu_a_d   = cmd_a;
            alu_b_d   = cmd_b;
            state_d   = S_ALU;
          end
        end
      end
      S_ALU: begin
        rsp_data_d = alu_out;
        rsp_ovf_d  = (alu_sel_q == 3'b000) ? alu_ovf : 1'b0;
        state_d    = S_RESP;
      end
      S_SHIFT: begin
        if (count_q == 3'd0) begin
          rsp_data_d = shreg_q;
          rsp_ovf_d  = sticky_q;
          state_d    = S_RESP;
        end else begin
          if (dir_right_q) begin
            shreg_d = {1'b0, shreg_q[7:1]};
          end else begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            sticky_d = sticky_q | shreg_q[7];
          end
          count_d = count_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign alu_sel   = alu_sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_op_sequencer;

  logic       clock = 1'b0;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_ovf;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer dut (
    .clock(clock), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clock = ~clock;

  // ALU model: add with carry-in 0; carry reported for add only.
  always_comb begin
    alu_out = 8'h00;
    alu_ovf = 1'b0;
    case (alu_sel)
      3'b000:  {alu_ovf, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b100:  alu_out = alu_a ^ alu_b;
      3'b101:  alu_out = ~alu_a;
      default: alu_out = 8'h00;
    endcase
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat,
                        input logic [7:0] exp_d, input logic exp_o);
    int lat;
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    step();
    cmd_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    if (op[2:1] != 2'b11) chk({tag, "_alu_sel"}, alu_sel, op);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_ovf"}, rsp_ovf, exp_o);
    if (rsp_ready) begin
      step();
      chk({tag, "_done_valid"}, rsp_valid, 0);
      chk({tag, "_done_ready"}, cmd_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int seen;
    clear = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outs", {alu_sel, alu_a, alu_b, rsp_data, rsp_ovf}, 0);
    step();
    step();
    clear = 1'b0;
    step();

    run_op("add", 3'b000, 8'hFF, 8'h01, 2, 8'h00, 1'b1);
    run_op("and", 3'b010, 8'hA0, 8'h2C, 2, 8'h20, 1'b0);
    run_op("xor", 3'b100, 8'h23, 8'h2C, 2, 8'h0F, 1'b0);
    run_op("not", 3'b101, 8'h0F, 8'h00, 2, 8'hF0, 1'b0);
    run_op("sub", 3'b001, 8'h10, 8'h20, 2, 8'hF0, 1'b0);
    run_op("shl3", 3'b110, 8'h81, 8'h03, 5, 8'h08, 1'b1);
    chk("shl_hold_alu_a", alu_a, 8'h10);
    chk("shl_hold_alu_sel", alu_sel, 3'b001);
    run_op("shl0", 3'b110, 8'h81, 8'h00, 2, 8'h81, 1'b0);
    run_op("shr4", 3'b111, 8'hF0, 8'h04, 6, 8'h0F, 1'b0);
    run_op("or", 3'b011, 8'h55, 8'hAA, 2, 8'hFF, 1'b0);
    run_op("shr7", 3'b111, 8'h80, 8'hFF, 9, 8'h01, 1'b0);

    // Response backpressure with new commands pulsing.
    rsp_ready = 1'b0;
    run_op("bp", 3'b010, 8'hF0, 8'h3C, 2, 8'h30, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = (i != 1); cmd_op = 3'b100; cmd_a = 8'h11; cmd_b = 8'h22;
      step();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 8'h30);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_alu_a", alu_a, 8'hF0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_ready", cmd_ready, 1);
    step();
    chk("bp_not_queued", busy, 0);
    chk("bp_not_queued_a", alu_a, 8'hF0);

    // Asynchronous clear in the middle of a shift.
    cmd_valid = 1'b1; cmd_op = 3'b110; cmd_a = 8'hFF; cmd_b = 8'h07;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    chk("mid_shift_busy", busy, 1);
    #2;
    clear = 1'b1;
    #1;
    chk("clr_cmd_ready", cmd_ready, 1);
    chk("clr_busy", busy, 0);
    chk("clr_rsp_valid", rsp_valid, 0);
    chk("clr_outs", {alu_sel, alu_a, alu_b, rsp_data, rsp_ovf}, 0);
    step();
    clear = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid || busy) seen++;
    end
    chk("clr_no_response", seen, 0);
    run_op("post_clr", 3'b000, 8'h01, 8'h02, 2, 8'h03, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
